// File: rtl/lfsr_range_sampler_if.sv
// Stream/bus bundle between the 16-bit training LFSR, the range sampler
// and the training datapath that consumes samples.
//   en_i      : run request into the sampler
//   limit_i   : exclusive upper bound for samples (0 means 2^OUT_W)
//   lfsr_i    : current LFSR state, registered upstream
//   lfsr_en_o : advance request back to the LFSR
//   sample_o  : sample value, qualified by valid_o
//   valid_o   : sample available
//   ready_i   : consumer accepts the sample when it and valid_o are high
//   rej_cnt_o : saturating count of rejected draws since reset
// The sampler connects through the slave modport, its driver through master.
interface lfsr_range_sampler_if #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 8
);
  logic              en_i;
  logic [OUT_W-1:0]  limit_i;
  logic [LFSR_W-1:0] lfsr_i;
  logic              lfsr_en_o;
  logic [OUT_W-1:0]  sample_o;
  logic              valid_o;
  logic              ready_i;
  logic [15:0]       rej_cnt_o;

  modport slave (
    input  en_i, limit_i, lfsr_i, ready_i,
    output lfsr_en_o, sample_o, valid_o, rej_cnt_o
  );

  modport master (
    output en_i, limit_i, lfsr_i, ready_i,
    input  lfsr_en_o, sample_o, valid_o, rej_cnt_o
  );
endinterface

// File: rtl/lfsr_range_sampler.sv
// Converts LFSR words into uniform integers in [0, limit) using
// mask-and-reject sampling with a bounded number of rejections, and
// presents them on a valid/ready stream.
// Ports:
//   clk_i : single clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : lfsr_range_sampler_if slave modport (run request, limit,
//           LFSR word/advance, sample stream, rejection counter)
module lfsr_range_sampler #(
  parameter int OUT_W   = 8,
  parameter int MAX_REJ = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lfsr_range_sampler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Smallest 2^k-1 covering x: OR every bit into all lower positions.
  function automatic logic [OUT_W-1:0] smear(input logic [OUT_W-1:0] x);
    logic [OUT_W-1:0] r;
    r = x;
    for (int s = 1; s < OUT_W; s = s * 2) begin
      r = r | (r >> s);
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] limit_q, limit_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [OUT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic [3:0]       rej_run_q, rej_run_d;
  logic [15:0]      rej_cnt_q, rej_cnt_d;

  logic             draw_s;
  logic [OUT_W-1:0] v_s;
  logic             in_range_s;

  // A draw needs an empty output slot or one being popped this cycle.
  assign draw_s     = (state_q == ST_RUN) && bus.en_i && (!valid_q || bus.ready_i);
  assign v_s        = bus.lfsr_i[OUT_W-1:0] & mask_q;
  assign in_range_s = (limit_q == '0) || (v_s < limit_q);

  assign bus.lfsr_en_o = draw_s && !rst_i;
  assign bus.sample_o  = sample_q;
  assign bus.valid_o   = valid_q;
  assign bus.rej_cnt_o = rej_cnt_q;

  // Next-state and datapath decisions for the sampler FSM.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    mask_d    = mask_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    rej_run_d = rej_run_q;
    rej_cnt_d = rej_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en_i) begin
          limit_d = bus.limit_i;
          // limit 0 wraps to all ones, i.e. the full range with no rejection.
          mask_d  = smear(bus.limit_i - OUT_W'(1));
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!bus.en_i) begin
          rej_run_d = 4'd0;
          valid_d   = valid_q && !bus.ready_i;
          state_d   = (valid_q && !bus.ready_i) ? ST_DRAIN : ST_IDLE;
        end else if (draw_s) begin
          if (in_range_s) begin
            sample_d  = v_s;
            valid_d   = 1'b1;
            rej_run_d = 4'd0;
          end else if (rej_run_q < 4'(MAX_REJ)) begin
            rej_run_d = rej_run_q + 4'd1;
            if (rej_cnt_q != 16'hFFFF) begin
              rej_cnt_d = rej_cnt_q + 16'd1;
            end else begin
              rej_cnt_d = rej_cnt_q;
            end
            valid_d = valid_q && !bus.ready_i;
          end else begin
            // v <= mask < 2*limit, so the difference lands inside [0, limit).
            sample_d  = v_s - limit_q;
            valid_d   = 1'b1;
            rej_run_d = 4'd0;
          end
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DRAIN: begin
        if (!valid_q || bus.ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      limit_q   <= '0;
      mask_q    <= '1;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      rej_run_q <= 4'd0;
      rej_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      mask_q    <= mask_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      rej_run_q <= rej_run_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
module tb_lfsr_range_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lfsr_range_sampler_if #(.LFSR_W(16), .OUT_W(8)) bus ();

  lfsr_range_sampler #(.OUT_W(8), .MAX_REJ(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Upstream LFSR: x^16+x^14+x^13+x^11+1, shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  logic [15:0] lfsr_q = 16'h0001;
  logic [15:0] seed = 16'h0001;
  logic [15:0] lfsr_const = 16'h0000;
  bit lfsr_load = 1'b0;
  bit use_real = 1'b0;

  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= seed;
    else if (bus.lfsr_en_o) lfsr_q <= lfsr_next(lfsr_q);
  end
  assign bus.lfsr_i = use_real ? lfsr_q : lfsr_const;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en_i = 1'b0; bus.ready_i = 1'b0; lfsr_load = 1'b1;
    tick(); tick();
    rst = 1'b0; lfsr_load = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int cyc);
    cyc = 0;
    while (!bus.valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({nm, "_valid"}, 32'(bus.valid_o), 32'd1);
  endtask

  // Reference: mask is the smallest 2^k-1 that is at least limit-1.
  function automatic int model_mask(input int lim);
    if (lim == 0) return 255;
    for (int k = 0; k <= 8; k++) if ((1 << k) - 1 >= lim - 1) return (1 << k) - 1;
    return 255;
  endfunction

  // Scoreboard for the random phase: predicts each draw's outcome from the word.
  bit mon_on = 1'b0;
  int model_limit = 0;
  int model_rej = 0;
  int model_run = 0;
  int exp_q[$];

  always @(negedge clk) begin
    if (!mon_on) begin
      exp_q.delete();
      model_rej = 0;
      model_run = 0;
    end else begin
      int v, e;
      chk("rej_cnt", 32'(bus.rej_cnt_o), 32'(model_rej));
      if (bus.valid_o && !bus.ready_i) begin
        chk("stall_no_draw", 32'(bus.lfsr_en_o), 32'd0);
        if (exp_q.size() != 0) chk("held_sample", 32'(bus.sample_o), 32'(exp_q[0]));
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pop_sample", 32'(bus.sample_o), 32'(e));
          if (model_limit != 0) chk("pop_in_range", 32'(int'(bus.sample_o) < model_limit), 32'd1);
        end
      end
      if (!bus.en_i) model_run = 0;
      if (bus.lfsr_en_o) begin
        v = int'(bus.lfsr_i[7:0]) & model_mask(model_limit);
        if (model_limit == 0 || v < model_limit) begin
          exp_q.push_back(v); model_run = 0;
        end else if (model_run < 4) begin
          model_run++;
          if (model_rej < 65535) model_rej++;
        end else begin
          exp_q.push_back(v - model_limit); model_run = 0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0]  limit;
    logic [15:0] word;
    logic [7:0]  exp_sample;
    logic [15:0] exp_rej;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int cyc;
    logic [7:0] held;
    logic [15:0] hl;
    logic [7:0] stream_exp[5];
    int lims[7];

    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [7:0] held;
    logic [15:0] hl;
    logic [7:0] stream_exp[5];
    int lims[7];

    tbl[0] = '{8'd200, 16'h00FF, 8'd55,  16'd4};
    tbl[1] = '{8'd0,   16'h12AB, 8'hAB,  16'd0};
    tbl[2] = '{8'd1,   16'hFFFF, 8'd0,   16'd0};
    tbl[3] = '{8'd16,  16'h0037, 8'd7,   16'd0};
    tbl[4] = '{8'd5,   16'h0006, 8'd1,   16'd4};
    tbl[5] = '{8'd5,   16'h0003, 8'd3,   16'd0};
    tbl[6] = '{8'd128, 16'h00FF, 8'd127, 16'd0};
    tbl[7] = '{8'd129, 16'h00FF, 8'd126, 16'd4};
    tbl[8] = '{8'd3,   16'h00F3, 8'd0,   16'd4};
    stream_exp[0] = 8'd1; stream_exp[1] = 8'd2; stream_exp[2] = 8'd4;
    stream_exp[3] = 8'd8; stream_exp[4] = 8'd0;
    lims[0] = 200; lims[1] = 129; lims[2] = 5; lims[3] = 3;
    lims[4] = 0;   lims[5] = 1;   lims[6] = 100;

    bus.en_i = 1'b0; bus.ready_i = 1'b0; bus.limit_i = 8'd0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_sample", 32'(bus.sample_o), 32'd0);
    chk("rst_rej", 32'(bus.rej_cnt_o), 32'd0);
    chk("rst_lfsr_en", 32'(bus.lfsr_en_o), 32'd0);

    // Table: constant word, one sample each, held with ready low
    for (int i = 0; i < 9; i++) begin
      do_reset();
      use_real = 1'b0; lfsr_const = tbl[i].word; bus.limit_i = tbl[i].limit;
      bus.en_i = 1'b1;
      wait_valid($sformatf("tbl%0d", i), cyc);
      chk($sformatf("tbl%0d_sample", i), 32'(bus.sample_o), 32'(tbl[i].exp_sample));
      chk($sformatf("tbl%0d_rej", i), 32'(bus.rej_cnt_o), 32'(tbl[i].exp_rej));
    end

    // Forced accept: latency, two samples, counter 4 then 8
    do_reset();
    use_real = 1'b0; lfsr_const = 16'h00FF; bus.limit_i = 8'd200; bus.en_i = 1'b1;
    wait_valid("forced1", cyc);
    chk("forced1_latency", 32'(cyc), 32'd6);
    chk("forced1_sample", 32'(bus.sample_o), 32'd55);
    chk("forced1_rej", 32'(bus.rej_cnt_o), 32'd4);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("forced_pop_clears", 32'(bus.valid_o), 32'd0);
    wait_valid("forced2", cyc);
    chk("forced2_sample", 32'(bus.sample_o), 32'd55);
    chk("forced2_rej", 32'(bus.rej_cnt_o), 32'd8);

    // Reset mid-run with a pending sample, en held high
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_sample", 32'(bus.sample_o), 32'd0);
    chk("midrst_rej", 32'(bus.rej_cnt_o), 32'd0);
    chk("midrst_lfsr_en", 32'(bus.lfsr_en_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_idle_no_draw", 32'(bus.lfsr_en_o), 32'd0);

    // Streaming from a real LFSR seeded 0x0001
    seed = 16'h0001;
    do_reset();
    use_real = 1'b1; bus.limit_i = 8'd16; bus.ready_i = 1'b1; bus.en_i = 1'b1;
    tick();
    chk("stream_first_latency", 32'(bus.valid_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(bus.valid_o), 32'd1);
      chk($sformatf("stream%0d_sample", i), 32'(bus.sample_o), 32'(stream_exp[i]));
    end
    chk("stream_rej", 32'(bus.rej_cnt_o), 32'd0);

    // Backpressure: hold 5 cycles, then pop and accept together
    bus.ready_i = 1'b0;
    #1;
    held = bus.sample_o; hl = lfsr_q;
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_draw", 32'(bus.lfsr_en_o), 32'd0);
      tick();
      chk("bp_sample_hold", 32'(bus.sample_o), 32'(held));
      chk("bp_valid_hold", 32'(bus.valid_o), 32'd1);
      chk("bp_lfsr_hold", 32'(lfsr_q), 32'(hl));
    end
    bus.ready_i = 1'b1;
    #1;
    chk("bp_release_draw", 32'(bus.lfsr_en_o), 32'd1);
    tick();
    chk("bp_valid_stays", 32'(bus.valid_o), 32'd1);
    chk("bp_lfsr_adv", 32'(lfsr_q), 32'(lfsr_next(hl)));
    chk("bp_new_sample", 32'(bus.sample_o), 32'(hl & 16'h000F));

    // Drain and relatch with a new limit
    do_reset();
    use_real = 1'b0; lfsr_const = 16'h0006; bus.limit_i = 8'd16; bus.en_i = 1'b1;
    wait_valid("drain_first", cyc);
    chk("drain_first_sample", 32'(bus.sample_o), 32'd6);
    bus.en_i = 1'b0;
    tick();
    bus.limit_i = 8'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_no_draw", 32'(bus.lfsr_en_o), 32'd0);
      chk("drain_valid", 32'(bus.valid_o), 32'd1);
      chk("drain_sample", 32'(bus.sample_o), 32'd6);
      tick();
    end
    bus.ready_i = 1'b1;
    tick();
    chk("drain_popped", 32'(bus.valid_o), 32'd0);
    bus.ready_i = 1'b0; lfsr_const = 16'h000C; bus.en_i = 1'b1;
    wait_valid("relatch", cyc);
    chk("relatch_mask7_sample", 32'(bus.sample_o), 32'd4);
    chk("relatch_rej", 32'(bus.rej_cnt_o), 32'd0);
    seed = 16'hACE1; lfsr_load = 1'b1;
    tick();
    lfsr_load = 1'b0; use_real = 1'b1; bus.ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o) chk("relatch_below5", 32'(bus.sample_o < 8'd5), 32'd1);
    end

    // Random phase against the scoreboard
    seed = 16'(($urandom & 32'hFFFE) | 32'h1);
    do_reset();
    use_real = 1'b1;
    mon_on = 1'b1;
    for (int r = 0; r < 7; r++) begin
      model_limit = (r == 6) ? int'($urandom_range(2, 255)) : lims[r];
      bus.limit_i = 8'(model_limit);
      bus.en_i = 1'b1;
      for (int c = 0; c < 180; c++) begin
        tick();
        bus.ready_i = ($urandom_range(0, 3) != 0);
      end
      bus.en_i = 1'b0; bus.ready_i = 1'b1;
      tick(); tick(); tick();
      chk("rand_drained", 32'(bus.valid_o), 32'd0);
    end
    #5;
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_range_sampler.md
# lfsr_range_sampler

Downstream consumer of the 16-bit training LFSR. Pulls LFSR words by driving the LFSR's enable, converts each word into a uniform integer in [0, limit) by mask-and-reject sampling, and presents samples on a valid/ready stream to the training datapath, for example for random index and perturbation selection. Worst-case draw count per sample is bounded, so the back-pass controller never stalls indefinitely.

## Interface
- `LFSR_W`, 16: width of the LFSR word consumed.
- `OUT_W`, 8: sample width; uses `lfsr_i[OUT_W-1:0]`.
- `MAX_REJ`, 4: consecutive rejections allowed before a forced accept (1..15).
- `clk_i`  in  1  single clock, all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  run request; sampling is allowed while high.
- `limit_i`  in  OUT_W  exclusive upper bound; 0 means 2^OUT_W.
- `lfsr_i`  in  LFSR_W  current LFSR state (registered upstream).
- `lfsr_en_o`  out  1  advance request to the LFSR en input; combinational.
- `sample_o`  out  OUT_W  sample value, valid when `valid_o` is high.
- `valid_o`  out  1  sample available.
- `ready_i`  in  1  consumer accepts the sample when it and `valid_o` are both high.
- `rej_cnt_o`  out  16  total rejected draws since reset; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE:**
  - `lfsr_en_o`=0.
  - When `en_i`=1: latch `limit_q<=limit_i` and `mask_q<=smear(limit_i-1)`, the OR-right-smear, i.e. the smallest 2^k-1 that is at least limit-1. Go to RUN.
  - `limit_i`=0 gives `mask_q` all ones with no rejection possible. `limit_i`=1 gives `mask_q`=0, so every sample is 0.
- **RUN:**
  - Draw condition: `lfsr_en_o = !valid_o || ready_i`. Each draw consumes the current `lfsr_i` and advances the LFSR at the same edge.
  - Per draw, `v = lfsr_i[OUT_W-1:0] & mask_q`:
    - `v < limit_q`, or `limit_q`=0: accept. `sample_o<=v`, `valid_o<=1`, clear `rej_run`.
    - Otherwise, if `rej_run < MAX_REJ`: reject. `rej_run++`, `rej_cnt_o++` (saturating), `valid_o` follows the pop rule.
    - Otherwise, forced accept: `sample_o<=v-limit_q`, `valid_o<=1`, clear `rej_run`. This value is always below limit because `v <= mask_q < 2*limit_q`.
  - Pop: `valid_o && ready_i` with no accept in the same cycle clears `valid_o` at the next edge. A pop and an accept in the same cycle keep `valid_o`=1 and load the new sample.
  - `en_i`=0 in RUN: no draw that cycle. Go to DRAIN if `valid_o`=1, else to IDLE. Clear `rej_run`.
- **DRAIN:**
  - `lfsr_en_o`=0.
  - Hold `sample_o`/`valid_o` until popped, then go to IDLE.
  - `en_i` re-asserting in DRAIN has no effect until IDLE is reached; the limit is re-latched there.
- Changes to `limit_i` while in RUN or DRAIN are ignored.
- Reset values, at the first edge with `rst_i`=1, regardless of state:
  - state=IDLE, `valid_o`=0, `sample_o`=0.
  - `rej_cnt_o`=0, `rej_run`=0.
  - `limit_q`=0, `mask_q`=all ones.
  - `lfsr_en_o`=0 while `rst_i` is high.
- Reset mid-operation discards any pending sample.
- Arithmetic is unsigned and OUT_W-wide. The comparison and subtraction never wrap because of the mask bound above.

## Timing
- `lfsr_en_o` is combinational from state, `valid_o` and `ready_i`. It has no path from `lfsr_i`.
- Latency:
  - `en_i` rises (IDLE) at edge N → first draw in cycle N+1 → `valid_o` high after edge N+2 if that draw is accepted.
  - Each rejection adds 1 cycle.
  - Worst case per sample is MAX_REJ+1 draws.
- Throughput is 1 sample/cycle with `ready_i` held high and no rejections.
- `sample_o` is stable while `valid_o`=1 and `ready_i`=0.
- The LFSR does not advance while stalled.
- `rej_cnt_o` updates at the edge that consumes the rejected word.

## Test plan
- **Reset:** hold `rst_i` 2 cycles mid-RUN with `valid_o`=1 → next cycle `valid_o`=0, `sample_o`=0, `rej_cnt_o`=0, `lfsr_en_o`=0, state IDLE.
- **Streaming:** real LFSR seeded 0x0001, `limit_i`=16, `en_i`=1, `ready_i`=1 → samples 1, 2, 4, 8, 0 on consecutive cycles (LFSR 0x0001, 0x0002, 0x0004, 0x0008, 0x0010), `rej_cnt_o`=0.
- **Forced accept:** bench drives `lfsr_i`=0x00FF constant, `limit_i`=200 (`mask_q`=0xFF) → 4 rejections then forced accept `sample_o`=55; `rej_cnt_o`=4, then 8 after the second sample.
- **Backpressure:** `ready_i`=0 for 5 cycles after first valid → `sample_o` constant, `lfsr_en_o`=0, LFSR state unchanged. Then `ready_i`=1 → pop and new accept in the same cycle, `valid_o` stays high.
- **Limits 0 and 1:** `limit_i`=0 → `sample_o` equals `lfsr_i[7:0]`, never rejected. `limit_i`=1 → every sample 0, no rejections.
- **Drain/relatch:** drop `en_i` with `valid_o`=1 and `ready_i`=0, then change `limit_i` 16→5 → sample held, no draws; pop → IDLE. Re-assert `en_i` → `mask_q`=7 and all further samples below 5.
